pong_match_ctrl: RTL and testbench

Match sequencer for the two-player pong design: it owns the score registers and the game state machine, and gates the ball and paddle animation. It sits between the ball block and the rest of the top level. It consumes the ball's goal pulses and the frame-end animate strobe. It drives run/recentre enables back to the ball, paddle enables, and scores/state to the seven-segment display driver.

---
 rtl/pong_pkg.sv | 20 ++
 rtl/frame_timer.sv | 38 +++
 rtl/pong_match_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer: game states,
// winner encodings, default score width and frame-timer width.
package pong_pkg;

    localparam int SCORE_W_DEF = 4;
    localparam int TIMER_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter. Counts i_animate strobes after a load and
// emits a one-cycle o_done pulse in the cycle after the strobe reaching 0.
module frame_timer
    import pong_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_animate,
    output logic               o_done
);

    logic [TIMER_W-1:0] count;
    logic               armed;

    // Load wins over a coincident strobe, so a strobe in the entry cycle is not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count  <= '0;
            armed  <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_load) begin
                count <= i_load_val;
                armed <= 1'b1;
            end else if (armed && i_animate) begin
                count <= count - 1'b1;
                if (count == TIMER_W'(1)) begin
                    armed  <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: score registers, game FSM and ball/paddle gating.
// Define PONG_WIN_BY_TWO_EN to require a two-point lead (saturation still ends the match).
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 120,
    parameter int POINT_FRAMES = 60,
    parameter int SCORE_W      = SCORE_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_animate,
    input  logic               i_start,
    input  logic               i_goal_p1,
    input  logic               i_goal_p2,
    output logic               o_ball_run,
    output logic               o_ball_reset,
    output logic               o_serve_dir,
    output logic               o_paddle_en,
    output logic [SCORE_W-1:0] o_score_p1,
    output logic [SCORE_W-1:0] o_score_p2,
    output logic [2:0]         o_state,
    output logic [1:0]         o_winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    state_t             state;
    logic               start_q;
    logic               start_rise;
    logic               tim_load;
    logic [TIMER_W-1:0] tim_val;
    logic               tim_done;
    logic               last_p2;
    logic               win_now;
    logic               win_p1;

    assign start_rise = i_start & ~start_q;
    assign o_state    = state;

    frame_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (tim_load),
        .i_load_val (tim_val),
        .i_animate  (i_animate),
        .o_done     (tim_done)
    );

    // Match-over decision from the current scores; consulted only at POINT expiry.
    always_comb begin
        win_now = 1'b0;
        win_p1  = 1'b0;
`ifdef PONG_WIN_BY_TWO_EN
        if (o_score_p1 == SCORE_MAX && o_score_p2 == SCORE_MAX) begin
            win_now = 1'b1;
            win_p1  = ~last_p2;
        end else if (o_score_p1 == SCORE_MAX || o_score_p2 == SCORE_MAX) begin
            win_now = 1'b1;
            win_p1  = (o_score_p1 > o_score_p2);
        end else if (o_score_p1 >= WIN_VAL &&
                     {1'b0, o_score_p1} >= {1'b0, o_score_p2} + (SCORE_W+1)'(2)) begin
            win_now = 1'b1;
            win_p1  = 1'b1;
        end else if (o_score_p2 >= WIN_VAL &&
                     {1'b0, o_score_p2} >= {1'b0, o_score_p1} + (SCORE_W+1)'(2)) begin
            win_now = 1'b1;
        end
`else
        if (o_score_p1 >= WIN_VAL) begin
            win_now = 1'b1;
            win_p1  = 1'b1;
        end else if (o_score_p2 >= WIN_VAL) begin
            win_now = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            tim_load     <= 1'b0;
            tim_val      <= '0;
            last_p2      <= 1'b0;
            o_ball_run   <= 1'b0;
            o_ball_reset <= 1'b0;
            o_serve_dir  <= 1'b0;
            o_paddle_en  <= 1'b1;
            o_score_p1   <= '0;
            o_score_p2   <= '0;
            o_winner     <= WIN_NONE;
        end else begin
            start_q      <= i_start;
            o_ball_reset <= 1'b0;
            tim_load     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_score_p1 <= '0;
                    o_score_p2 <= '0;
                    if (start_rise) begin
                        state        <= ST_SERVE;
                        o_ball_reset <= 1'b1;
                        o_serve_dir  <= 1'b0;
                        tim_load     <= 1'b1;
                        tim_val      <= TIMER_W'(SERVE_FRAMES);
                    end
                end
                ST_SERVE: begin
                    if (tim_done) begin
                        state      <= ST_PLAY;
                        o_ball_run <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (i_goal_p1 || i_goal_p2) begin
                        state      <= ST_POINT;
                        o_ball_run <= 1'b0;
                        tim_load   <= 1'b1;
                        tim_val    <= TIMER_W'(POINT_FRAMES);
                        if (i_goal_p1 && !i_goal_p2) begin
                            if (o_score_p1 != SCORE_MAX) o_score_p1 <= o_score_p1 + 1'b1;
                            o_serve_dir <= 1'b1;
                            last_p2     <= 1'b0;
                        end else if (i_goal_p2 && !i_goal_p1) begin
                            if (o_score_p2 != SCORE_MAX) o_score_p2 <= o_score_p2 + 1'b1;
                            o_serve_dir <= 1'b0;
                            last_p2     <= 1'b1;
                        end
                    end
                end
                ST_POINT: begin
                    if (tim_done) begin
                        if (win_now) begin
                            state       <= ST_OVER;
                            o_winner    <= win_p1 ? WIN_P1 : WIN_P2;
                            o_paddle_en <= 1'b0;
                        end else begin
                            state        <= ST_SERVE;
                            o_ball_reset <= 1'b1;
                            tim_load     <= 1'b1;
                            tim_val      <= TIMER_W'(SERVE_FRAMES);
                        end
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state        <= ST_SERVE;
                        o_score_p1   <= '0;
                        o_score_p2   <= '0;
                        o_winner     <= WIN_NONE;
                        o_ball_reset <= 1'b1;
                        o_serve_dir  <= 1'b0;
                        o_paddle_en  <= 1'b1;
                        tim_load     <= 1'b1;
                        tim_val      <= TIMER_W'(SERVE_FRAMES);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl with default parameters;
// the match-end expectations follow PONG_WIN_BY_TWO_EN when it is defined.
module tb_pong_match_ctrl;

    localparam int SERVE = 120;
    localparam int POINT = 60;
`ifdef PONG_WIN_BY_TWO_EN
    localparam int FINAL_P1 = 15;
    localparam int FINAL_P2 = 14;
`else
    localparam int FINAL_P1 = 9;
    localparam int FINAL_P2 = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       animate = 1'b0;
    logic       start = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic       ball_run, ball_reset, serve_dir, paddle_en;
    logic [3:0] score_p1, score_p2;
    logic [2:0] state;
    logic [1:0] winner;

    int tests = 0;
    int fails = 0;

    pong_match_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_animate    (animate),
        .i_start      (start),
        .i_goal_p1    (goal_p1),
        .i_goal_p2    (goal_p2),
        .o_ball_run   (ball_run),
        .o_ball_reset (ball_reset),
        .o_serve_dir  (serve_dir),
        .o_paddle_en  (paddle_en),
        .o_score_p1   (score_p1),
        .o_score_p2   (score_p2),
        .o_state      (state),
        .o_winner     (winner)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each strobe is one cycle wide with a quiet cycle after it.
    task automatic strobe(input int n);
        repeat (n) begin
            @(negedge clk) animate = 1'b1;
            @(negedge clk) animate = 1'b0;
        end
    endtask

    task automatic goal(input logic g1, input logic g2);
        goal_p1 = g1;
        goal_p2 = g2;
        @(negedge clk);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
    endtask

    // From a settled SERVE: serve, score, freeze, land settled in the next state.
    task automatic play_point(input logic g1, input logic g2);
        strobe(SERVE);
        tick(1);
        goal(g1, g2);
        strobe(POINT);
        tick(2);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_state"}, state, 0);
        check_output({tag, "_p1"}, score_p1, 0);
        check_output({tag, "_p2"}, score_p2, 0);
        check_output({tag, "_winner"}, winner, 0);
        check_output({tag, "_run"}, ball_run, 0);
        check_output({tag, "_breset"}, ball_reset, 0);
        check_output({tag, "_dir"}, serve_dir, 0);
        check_output({tag, "_paddle"}, paddle_en, 1);
    endtask

    initial begin
        tick(3);
        check_reset_values("rst");
        rst_n = 1'b1;
        tick(2);

        // Goals in IDLE must be ignored.
        goal(1'b1, 1'b0);
        goal(1'b0, 1'b1);
        tick(1);
        check_output("idle_goal_p1", score_p1, 0);
        check_output("idle_goal_p2", score_p2, 0);
        check_output("idle_state", state, 0);

        // Start edge; a strobe in the SERVE entry cycle is not counted.
        start = 1'b1;
        tick(1);
        check_output("start_state", state, 1);
        check_output("start_breset", ball_reset, 1);
        animate = 1'b1;
        tick(1);
        animate = 1'b0;
        check_output("start_breset_once", ball_reset, 0);
        start = 1'b0;
        strobe(SERVE - 1);
        check_output("serve_119_state", state, 1);
        strobe(1);
        check_output("serve_120_pending", state, 1);
        tick(1);
        check_output("play_state", state, 2);
        check_output("play_run", ball_run, 1);

        // Goal coincident with a strobe: the POINT timer must still need all 60.
        animate = 1'b1;
        goal(1'b0, 1'b1);
        animate = 1'b0;
        check_output("g2_score_p2", score_p2, 1);
        check_output("g2_score_p1", score_p1, 0);
        check_output("g2_state", state, 3);
        check_output("g2_dir", serve_dir, 0);
        check_output("g2_run", ball_run, 0);
        strobe(POINT - 1);
        check_output("point_59_state", state, 3);
        strobe(1);
        tick(1);
        check_output("reserve_state", state, 1);
        check_output("reserve_breset", ball_reset, 1);
        tick(1);

        // Reach 3-3 with player 1 scoring last, then a let.
        play_point(1'b0, 1'b1);
        play_point(1'b0, 1'b1);
        play_point(1'b1, 1'b0);
        play_point(1'b1, 1'b0);
        play_point(1'b1, 1'b0);
        check_output("pre_let_dir", serve_dir, 1);
        strobe(SERVE);
        tick(1);
        goal(1'b1, 1'b1);
        check_output("let_p1", score_p1, 3);
        check_output("let_p2", score_p2, 3);
        check_output("let_state", state, 3);
        check_output("let_dir", serve_dir, 1);
        strobe(POINT);
        tick(2);

`ifdef PONG_WIN_BY_TWO_EN
        repeat (5) play_point(1'b0, 1'b1);
        repeat (6) play_point(1'b1, 1'b0);
        check_output("by2_9_8_state", state, 1);
        check_output("by2_9_8_winner", winner, 0);
        repeat (5) begin
            play_point(1'b0, 1'b1);
            play_point(1'b1, 1'b0);
        end
        play_point(1'b0, 1'b1);
        check_output("by2_14_14_state", state, 1);
`else
        repeat (5) play_point(1'b1, 1'b0);
        check_output("p1_8_state", state, 1);
`endif
        // Match point for player 1.
        strobe(SERVE);
        tick(1);
        goal(1'b1, 1'b0);
        strobe(POINT);
        check_output("final_point_pending", state, 3);
        tick(1);
        check_output("over_state", state, 4);
        check_output("over_winner", winner, 1);
        check_output("over_paddle", paddle_en, 0);
        check_output("over_run", ball_run, 0);
        check_output("over_p1", score_p1, FINAL_P1);
        check_output("over_p2", score_p2, FINAL_P2);
        goal(1'b0, 1'b1);
        tick(1);
        check_output("over_goal_ignored", score_p2, FINAL_P2);

        // Restart from OVER.
        start = 1'b1;
        tick(1);
        check_output("restart_state", state, 1);
        check_output("restart_p1", score_p1, 0);
        check_output("restart_p2", score_p2, 0);
        check_output("restart_winner", winner, 0);
        check_output("restart_breset", ball_reset, 1);
        check_output("restart_paddle", paddle_en, 1);
        check_output("restart_dir", serve_dir, 0);
        start = 1'b0;
        tick(1);

        // Asynchronous reset 50 strobes into SERVE with a nonzero score.
        play_point(1'b0, 1'b1);
        check_output("pre_rst_p2", score_p2, 1);
        strobe(50);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_output("post_rst_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
